// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory req/ack access with timeout, branch resolution, stall/flush and MEM/WB register.
// Optional MEM_STAT_EN adds Stat_Accesses / Stat_StallCycles counters.
module mem_wb_stage #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_MemWre,
    input  logic        MEM_MemRead,
    input  logic [1:0]  MEM_BranchType,
    input  logic [1:0]  MEM_DBDataSrc,
    input  logic        MEM_RegWre,
    input  logic [31:0] MEM_PCadd4,
    input  logic [31:0] MEM_BranchPC,
    input  logic        MEM_Zero,
    input  logic        MEM_Sign,
    input  logic [31:0] MEM_DataIn,
    input  logic [31:0] MEM_ALUResult,
    input  logic [4:0]  MEM_WriteReg,
    output logic        DM_Req,
    output logic        DM_We,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WData,
    input  logic [31:0] DM_RData,
    input  logic        DM_Ack,
    output logic        Pipe_Stall,
    output logic        Branch_Taken,
    output logic [31:0] Branch_Target,
    output logic        Flush,
    output logic        Mem_Fault,
    output logic        WB_RegWre,
    output logic [4:0]  WB_WriteReg,
    output logic [31:0] WB_WriteData
`ifdef MEM_STAT_EN
    ,
    output logic [31:0] Stat_Accesses,
    output logic [31:0] Stat_StallCycles
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(ACK_TIMEOUT);

    state_t          state, state_next;
    logic [TO_W-1:0] cnt, cnt_next;
    logic            mem_op, misaligned, access;
    logic            timeout_now, ack_ok;
    logic [31:0]     mem_data, wb_data;

    assign mem_op     = MEM_MemRead | MEM_MemWre;
    assign misaligned = mem_op & (MEM_ALUResult[1:0] != 2'b00);
    assign access     = mem_op & ~misaligned;

    assign timeout_now = (state == S_WAIT) & (cnt == TIMEOUT_VAL) & ~DM_Ack;
    assign ack_ok      = access & DM_Ack;

    // Reset gates the request and stall combinationally so they drop the moment reset asserts.
    assign DM_Req     = Reset & access;
    assign DM_We      = MEM_MemWre;
    assign DM_Addr    = MEM_ALUResult;
    assign DM_WData   = MEM_DataIn;
    assign Pipe_Stall = Reset & access & ~DM_Ack & ~timeout_now;

    always_comb begin
        Branch_Taken = 1'b0;
        case (MEM_BranchType)
            2'b01:   Branch_Taken = MEM_Zero;
            2'b10:   Branch_Taken = ~MEM_Zero;
            2'b11:   Branch_Taken = MEM_Sign;
            default: Branch_Taken = 1'b0;
        endcase
    end

    assign Branch_Target = MEM_BranchPC;
    assign Flush         = Branch_Taken & ~Pipe_Stall;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (access && !DM_Ack) begin
                    state_next = S_WAIT;
                    cnt_next   = TO_W'(1);
                end
            end
            S_WAIT: begin
                if (DM_Ack || timeout_now || !access) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + TO_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Read data only counts when an issued request is acknowledged; aborts and misaligned loads yield 0.
    assign mem_data = ack_ok ? DM_RData : '0;

    always_comb begin
        wb_data = '0;
        case (MEM_DBDataSrc)
            2'b00:   wb_data = MEM_ALUResult;
            2'b01:   wb_data = mem_data;
            2'b10:   wb_data = MEM_PCadd4;
            default: wb_data = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Mem_Fault <= 1'b0;
        end else if (misaligned || timeout_now) begin
            Mem_Fault <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WB_RegWre    <= 1'b0;
            WB_WriteReg  <= '0;
            WB_WriteData <= '0;
        end else if (Pipe_Stall) begin
            WB_RegWre <= 1'b0;
        end else begin
            WB_RegWre    <= MEM_RegWre;
            WB_WriteReg  <= MEM_WriteReg;
            WB_WriteData <= wb_data;
        end
    end

`ifdef MEM_STAT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Stat_Accesses    <= '0;
            Stat_StallCycles <= '0;
        end else begin
            if (ack_ok || timeout_now)
                Stat_Accesses <= Stat_Accesses + 32'd1;
            if (Pipe_Stall)
                Stat_StallCycles <= Stat_StallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (ACK_TIMEOUT = 4); stat checks compile in with MEM_STAT_EN.
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MEM_MemWre, MEM_MemRead, MEM_RegWre, MEM_Zero, MEM_Sign;
    logic [1:0]  MEM_BranchType, MEM_DBDataSrc;
    logic [31:0] MEM_PCadd4, MEM_BranchPC, MEM_DataIn, MEM_ALUResult;
    logic [4:0]  MEM_WriteReg;
    logic        DM_Req, DM_We, DM_Ack;
    logic [31:0] DM_Addr, DM_WData, DM_RData;
    logic        Pipe_Stall, Branch_Taken, Flush, Mem_Fault, WB_RegWre;
    logic [31:0] Branch_Target, WB_WriteData;
    logic [4:0]  WB_WriteReg;
`ifdef MEM_STAT_EN
    logic [31:0] Stat_Accesses, Stat_StallCycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage #(.ACK_TIMEOUT(4), .TO_W(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .MEM_MemWre(MEM_MemWre), .MEM_MemRead(MEM_MemRead),
        .MEM_BranchType(MEM_BranchType), .MEM_DBDataSrc(MEM_DBDataSrc),
        .MEM_RegWre(MEM_RegWre), .MEM_PCadd4(MEM_PCadd4), .MEM_BranchPC(MEM_BranchPC),
        .MEM_Zero(MEM_Zero), .MEM_Sign(MEM_Sign), .MEM_DataIn(MEM_DataIn),
        .MEM_ALUResult(MEM_ALUResult), .MEM_WriteReg(MEM_WriteReg),
        .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr), .DM_WData(DM_WData),
        .DM_RData(DM_RData), .DM_Ack(DM_Ack),
        .Pipe_Stall(Pipe_Stall), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Flush(Flush), .Mem_Fault(Mem_Fault),
        .WB_RegWre(WB_RegWre), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData)
`ifdef MEM_STAT_EN
        , .Stat_Accesses(Stat_Accesses), .Stat_StallCycles(Stat_StallCycles)
`endif
    );

    task automatic clear_inputs();
        MEM_MemWre = 0; MEM_MemRead = 0; MEM_RegWre = 0; MEM_Zero = 0; MEM_Sign = 0;
        MEM_BranchType = 2'b00; MEM_DBDataSrc = 2'b00;
        MEM_PCadd4 = '0; MEM_BranchPC = '0; MEM_DataIn = '0; MEM_ALUResult = '0;
        MEM_WriteReg = '0; DM_Ack = 0; DM_RData = '0;
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 0;
        #3;
        checks++; if (DM_Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", DM_Req); end
        checks++; if (Pipe_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", Pipe_Stall); end
        checks++; if (Mem_Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", Mem_Fault); end
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== 38'd0) begin errors++; $display("FAIL reset_wb got %b/%h/%h exp 0", WB_RegWre, WB_WriteReg, WB_WriteData); end
        tick(); tick();
        Reset = 1;
        tick();
    endtask

    task automatic test_alu_writeback();
        MEM_RegWre = 1; MEM_DBDataSrc = 2'b00; MEM_ALUResult = 32'h55AA; MEM_WriteReg = 5'd7;
        MEM_PCadd4 = 32'h0000_2004;
        @(negedge Clk);
        checks++; if (DM_Req !== 1'b0 || Pipe_Stall !== 1'b0) begin errors++; $display("FAIL alu_nostall got req=%b stall=%b exp 0/0", DM_Req, Pipe_Stall); end
        tick();
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd7, 32'h55AA}) begin errors++; $display("FAIL alu_wb got %b/%0d/%h exp 1/7/000055aa", WB_RegWre, WB_WriteReg, WB_WriteData); end
        MEM_DBDataSrc = 2'b10; MEM_WriteReg = 5'd31;
        tick();
        checks++; if ({WB_WriteReg, WB_WriteData} !== {5'd31, 32'h0000_2004}) begin errors++; $display("FAIL pc4_wb got %0d/%h exp 31/00002004", WB_WriteReg, WB_WriteData); end
        MEM_DBDataSrc = 2'b11; MEM_RegWre = 0;
        tick();
        checks++; if ({WB_RegWre, WB_WriteData} !== {1'b0, 32'h0}) begin errors++; $display("FAIL zero_wb got %b/%h exp 0/00000000", WB_RegWre, WB_WriteData); end
        clear_inputs();
    endtask

    task automatic test_zero_wait_load();
        MEM_MemRead = 1; MEM_ALUResult = 32'h40; MEM_DBDataSrc = 2'b01; MEM_RegWre = 1;
        MEM_WriteReg = 5'd5; DM_Ack = 1; DM_RData = 32'hDEADBEEF;
        @(negedge Clk);
        checks++; if ({DM_Req, DM_We, Pipe_Stall} !== 3'b100) begin errors++; $display("FAIL zw_handshake got req=%b we=%b stall=%b exp 1/0/0", DM_Req, DM_We, Pipe_Stall); end
        checks++; if (DM_Addr !== 32'h40) begin errors++; $display("FAIL zw_addr got %h exp 00000040", DM_Addr); end
        tick();
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL zw_wb got %b/%0d/%h exp 1/5/deadbeef", WB_RegWre, WB_WriteReg, WB_WriteData); end
        clear_inputs();
    endtask

    task automatic test_wait_store();
        MEM_MemWre = 1; MEM_ALUResult = 32'h80; MEM_DataIn = 32'h1234; MEM_WriteReg = 5'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if ({DM_Req, DM_We, Pipe_Stall} !== 3'b111) begin errors++; $display("FAIL st_stall%0d got req=%b we=%b stall=%b exp 1/1/1", i, DM_Req, DM_We, Pipe_Stall); end
            checks++; if (DM_Addr !== 32'h80 || DM_WData !== 32'h1234) begin errors++; $display("FAIL st_stable%0d got %h/%h exp 00000080/00001234", i, DM_Addr, DM_WData); end
            tick();
            checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL st_bubble%0d got %b/%0d/%h exp 0/5/deadbeef", i, WB_RegWre, WB_WriteReg, WB_WriteData); end
        end
        DM_Ack = 1;
        @(negedge Clk);
        checks++; if (Pipe_Stall !== 1'b0) begin errors++; $display("FAIL st_ack_stall got %b exp 0", Pipe_Stall); end
        tick();
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b0, 5'd9, 32'h80}) begin errors++; $display("FAIL st_wb got %b/%0d/%h exp 0/9/00000080", WB_RegWre, WB_WriteReg, WB_WriteData); end
        clear_inputs();
    endtask

    task automatic test_wait_load();
        MEM_MemRead = 1; MEM_ALUResult = 32'h44; MEM_DBDataSrc = 2'b01; MEM_RegWre = 1;
        MEM_WriteReg = 5'd12; DM_RData = 32'hCAFEF00D;
        @(negedge Clk);
        checks++; if (Pipe_Stall !== 1'b1) begin errors++; $display("FAIL wl_stall got %b exp 1", Pipe_Stall); end
        tick();
        DM_Ack = 1;
        @(negedge Clk);
        checks++; if (Pipe_Stall !== 1'b0) begin errors++; $display("FAIL wl_ack_stall got %b exp 0", Pipe_Stall); end
        tick();
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd12, 32'hCAFEF00D}) begin errors++; $display("FAIL wl_wb got %b/%0d/%h exp 1/12/cafef00d", WB_RegWre, WB_WriteReg, WB_WriteData); end
        clear_inputs();
    endtask

    task automatic test_branch();
        MEM_BranchType = 2'b01; MEM_Zero = 1; MEM_BranchPC = 32'h100;
        @(negedge Clk);
        checks++; if ({Branch_Taken, Flush} !== 2'b11 || Branch_Target !== 32'h100) begin errors++; $display("FAIL beq_taken got %b%b/%h exp 11/00000100", Branch_Taken, Flush, Branch_Target); end
        tick();
        clear_inputs();
        @(negedge Clk);
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL beq_oneshot got %b exp 0", Flush); end
        tick();
        MEM_BranchType = 2'b10; MEM_Zero = 1;
        @(negedge Clk);
        checks++; if ({Branch_Taken, Flush} !== 2'b00) begin errors++; $display("FAIL bne_zero got %b%b exp 00", Branch_Taken, Flush); end
        MEM_Zero = 0;
        #1;
        checks++; if ({Branch_Taken, Flush} !== 2'b11) begin errors++; $display("FAIL bne_nz got %b%b exp 11", Branch_Taken, Flush); end
        tick();
        MEM_BranchType = 2'b11; MEM_Sign = 1; MEM_Zero = 1;
        @(negedge Clk);
        checks++; if ({Branch_Taken, Flush} !== 2'b11) begin errors++; $display("FAIL bltz_neg got %b%b exp 11", Branch_Taken, Flush); end
        MEM_Sign = 0;
        #1;
        checks++; if ({Branch_Taken, Flush} !== 2'b00) begin errors++; $display("FAIL bltz_pos got %b%b exp 00", Branch_Taken, Flush); end
        // Taken branch with a stalling access: flush held off; inputs cleared before any edge.
        MEM_BranchType = 2'b01; MEM_Zero = 1; MEM_MemRead = 1; MEM_ALUResult = 32'h50;
        #1;
        checks++; if ({Branch_Taken, Pipe_Stall, Flush} !== 3'b110) begin errors++; $display("FAIL br_stall got %b%b%b exp 110", Branch_Taken, Pipe_Stall, Flush); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        MEM_MemRead = 1; MEM_ALUResult = 32'h100; MEM_DBDataSrc = 2'b01; MEM_RegWre = 1;
        MEM_WriteReg = 5'd3; DM_RData = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++; if (Pipe_Stall !== 1'b1) begin errors++; $display("FAIL to_stall%0d got %b exp 1", i, Pipe_Stall); end
            checks++; if (Mem_Fault !== 1'b0) begin errors++; $display("FAIL to_nofault%0d got %b exp 0", i, Mem_Fault); end
            tick();
        end
        @(negedge Clk);
        checks++; if ({DM_Req, Pipe_Stall} !== 2'b10) begin errors++; $display("FAIL to_release got req=%b stall=%b exp 1/0", DM_Req, Pipe_Stall); end
        tick();
        clear_inputs();
        checks++; if (Mem_Fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b exp 1", Mem_Fault); end
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd3, 32'h0}) begin errors++; $display("FAIL to_wb got %b/%0d/%h exp 1/3/00000000", WB_RegWre, WB_WriteReg, WB_WriteData); end
        tick();
        checks++; if (Mem_Fault !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", Mem_Fault); end
`ifdef MEM_STAT_EN
        // zero-wait load, store, wait load, timeout; stalls 3 + 1 + 4.
        checks++; if (Stat_Accesses !== 32'd4) begin errors++; $display("FAIL stat_acc got %0d exp 4", Stat_Accesses); end
        checks++; if (Stat_StallCycles !== 32'd8) begin errors++; $display("FAIL stat_stall got %0d exp 8", Stat_StallCycles); end
`endif
        Reset = 0;
        #2;
        checks++; if (Mem_Fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", Mem_Fault); end
        Reset = 1;
        tick();
    endtask

    task automatic test_misaligned();
        MEM_MemRead = 1; MEM_ALUResult = 32'h41; MEM_DBDataSrc = 2'b01; MEM_RegWre = 1;
        MEM_WriteReg = 5'd4; DM_Ack = 1; DM_RData = 32'h11112222;
        @(negedge Clk);
        checks++; if ({DM_Req, Pipe_Stall, Mem_Fault} !== 3'b000) begin errors++; $display("FAIL mis_pre got req=%b stall=%b fault=%b exp 000", DM_Req, Pipe_Stall, Mem_Fault); end
        tick();
        clear_inputs();
        checks++; if (Mem_Fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", Mem_Fault); end
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd4, 32'h0}) begin errors++; $display("FAIL mis_wb got %b/%0d/%h exp 1/4/00000000", WB_RegWre, WB_WriteReg, WB_WriteData); end
    endtask

    task automatic test_reset_mid_access();
        MEM_MemRead = 1; MEM_ALUResult = 32'h48; MEM_DBDataSrc = 2'b01; MEM_RegWre = 1; MEM_WriteReg = 5'd6;
        tick(); tick();
        #2;
        checks++; if ({DM_Req, Pipe_Stall} !== 2'b11) begin errors++; $display("FAIL mid_wait got req=%b stall=%b exp 1/1", DM_Req, Pipe_Stall); end
        Reset = 0;
        #1;
        checks++; if ({DM_Req, Pipe_Stall} !== 2'b00) begin errors++; $display("FAIL mid_drop got req=%b stall=%b exp 0/0", DM_Req, Pipe_Stall); end
        checks++; if ({Mem_Fault, WB_RegWre, WB_WriteReg, WB_WriteData} !== 39'd0) begin errors++; $display("FAIL mid_regs got %b/%b/%0d/%h exp 0", Mem_Fault, WB_RegWre, WB_WriteReg, WB_WriteData); end
`ifdef MEM_STAT_EN
        checks++; if (Stat_Accesses !== 32'd0 || Stat_StallCycles !== 32'd0) begin errors++; $display("FAIL mid_stat got %0d/%0d exp 0/0", Stat_Accesses, Stat_StallCycles); end
`endif
        #1;
        Reset = 1;
        #1;
        checks++; if ({DM_Req, Pipe_Stall} !== 2'b11) begin errors++; $display("FAIL mid_release got req=%b stall=%b exp 1/1", DM_Req, Pipe_Stall); end
        tick();
        DM_Ack = 1; DM_RData = 32'h0BADF00D;
        tick();
        checks++; if ({WB_RegWre, WB_WriteReg, WB_WriteData} !== {1'b1, 5'd6, 32'h0BADF00D}) begin errors++; $display("FAIL mid_after got %b/%0d/%h exp 1/6/0badf00d", WB_RegWre, WB_WriteReg, WB_WriteData); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_zero_wait_load();
        test_wait_store();
        test_wait_load();
        test_branch();
        test_timeout();
        test_misaligned();
        test_reset_mid_access();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs the data-memory access over a req/ack handshake, resolves branches from BranchType/Zero/Sign, and generates Pipe_Stall and the branch flush for upstream pipeline registers.
- Contains the MEM/WB pipeline register that feeds register-file write-back.

Parameters:
- ACK_TIMEOUT, 16: max wait cycles for DM_Ack before the access is aborted; range 1..255.
- TO_W, 8: width of the timeout counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MEM_MemWre  in  1  store request from EX/MEM.
- MEM_MemRead  in  1  load request from EX/MEM.
- MEM_BranchType  in  2  00 none, 01 beq, 10 bne, 11 bltz.
- MEM_DBDataSrc  in  2  write-back select: 00 ALU, 01 memory, 10 PCadd4, 11 zero.
- MEM_RegWre  in  1  register write enable.
- MEM_PCadd4  in  32  PC+4 of the instruction.
- MEM_BranchPC  in  32  branch target.
- MEM_Zero  in  1  ALU zero flag.
- MEM_Sign  in  1  ALU sign flag.
- MEM_DataIn  in  32  store data.
- MEM_ALUResult  in  32  ALU result / memory byte address.
- MEM_WriteReg  in  5  destination register.
- DM_Req  out  1  memory request.
- DM_We  out  1  1 = write, 0 = read.
- DM_Addr  out  32  word-aligned byte address.
- DM_WData  out  32  write data.
- DM_RData  in  32  read data, valid when DM_Ack = 1.
- DM_Ack  in  1  one-cycle completion pulse.
- Pipe_Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- Branch_Taken  out  1  branch condition true.
- Branch_Target  out  32  equals MEM_BranchPC.
- Flush  out  1  flush IF/ID, ID/EX and EX/MEM.
- Mem_Fault  out  1  sticky fault flag: misalignment or timeout.
- WB_RegWre  out  1  registered write enable.
- WB_WriteReg  out  5  registered destination register.
- WB_WriteData  out  32  registered write-back data.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - State IDLE, timeout counter 0, Mem_Fault 0.
  - All WB_* outputs 0.
  - Combinational outputs follow from the cleared state.
- Access qualification:
  - mem_op = MEM_MemRead | MEM_MemWre.
  - misaligned = mem_op & (MEM_ALUResult[1:0] != 0).
  - access = mem_op & ~misaligned.
  - If both MemRead and MemWre are set, the operation is a write.
- Handshake:
  - DM_Req = access while in IDLE or WAIT.
  - DM_We = MEM_MemWre.
  - DM_Addr = MEM_ALUResult; DM_WData = MEM_DataIn.
  - All request outputs are held stable while stalled; their sources are frozen.
  - Zero-wait acknowledge (DM_Ack in the same cycle as DM_Req) is legal.
  - DM_Ack while DM_Req = 0 is ignored.
- FSM:
  - IDLE -> WAIT when access & ~DM_Ack; counter loads 1.
  - WAIT -> IDLE on DM_Ack.
  - WAIT -> IDLE on timeout (counter == ACK_TIMEOUT & ~DM_Ack): sets Mem_Fault, read data taken as 0.
  - WAIT with no ack and no timeout: stay, counter increments.
  - Mem_Fault is cleared only by reset.
- Pipe_Stall = access & ~DM_Ack & ~timeout_now.
- Misaligned access:
  - No request is issued and no stall occurs.
  - Mem_Fault sets on the next edge.
  - Read data is taken as 0; a store is dropped.
- Branch:
  - Branch_Taken = (01 & Zero) | (10 & ~Zero) | (11 & Sign).
  - Flush = Branch_Taken & ~Pipe_Stall; asserted for one cycle per branch instruction.
- MEM/WB register, rising edge:
  - If ~Pipe_Stall: load MEM_RegWre, MEM_WriteReg, and the data selected by MEM_DBDataSrc. Memory data is DM_RData on the ack cycle, else 0.
  - If Pipe_Stall: load a bubble (WB_RegWre = 0); WB_WriteReg and WB_WriteData hold.
- Latency:
  - Non-memory instruction: one cycle to the WB outputs.
  - Load: 1 + wait cycles.
- Reset mid-access: FSM returns to IDLE immediately and DM_Req follows the inputs after reset is released.

Optional Feature:
- Macro: MEM_STAT_EN.
- Defined: adds outputs Stat_Accesses (32) and Stat_StallCycles (32).
  - Stat_Accesses increments on each completed or aborted access.
  - Stat_StallCycles increments on every cycle with Pipe_Stall = 1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are absent and no counter logic is generated.

Test Plan:
- Zero-wait load: MemRead = 1, ALUResult = 0x40, DBDataSrc = 01, WriteReg = 5, DM_Ack in the same cycle with RData = 0xDEADBEEF -> no stall; next edge gives WB_RegWre = 1, WB_WriteReg = 5, WB_WriteData = 0xDEADBEEF.
- 3-wait store: MemWre = 1, ALUResult = 0x80, DataIn = 0x1234, ack on the 4th cycle -> Pipe_Stall high for 3 cycles; DM_Addr/DM_WData stable at 0x80/0x1234; 3 bubbles then one write-back load.
- Timeout: ACK_TIMEOUT = 4, no ack -> Pipe_Stall high for exactly 4 cycles, then Mem_Fault = 1 and WB_WriteData = 0.
- Misaligned: MemRead = 1, ALUResult = 0x41 -> DM_Req = 0, no stall, Mem_Fault = 1 after the next edge.
- Branches:
  - BranchType = 01, Zero = 1, BranchPC = 0x100 -> Branch_Taken = 1, Flush = 1 for one cycle, Branch_Target = 0x100.
  - BranchType = 10 with Zero = 1 -> no flush.
  - BranchType = 11 with Sign = 1 -> flush.
- Reset asserted during WAIT -> DM_Req and Pipe_Stall drop at once; WB_* and Mem_Fault read 0; Stat counters read 0 with MEM_STAT_EN defined.
